// File: rtl/multi_channel_serial_shifter_pkg.sv
// Shared types for the multi-channel serial shifter: op codes, FSM states, legality check.
// ROTATE_EN selects whether ROL/ROR are legal ops.
package shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef ROTATE_EN
    return op <= 3'd4;
`else
    return op <= 3'd2;
`endif
  endfunction

endpackage

// File: rtl/multi_channel_serial_shifter_if.sv
// Request/result handshake bundle for the multi-channel serial shifter.
interface multi_channel_serial_shifter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SHAMT_W  = $clog2(WIDTH)
);
  import shifter_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [OP_W-1:0]           in_op;
  logic [SHAMT_W-1:0]        in_shamt;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_carry;
  logic                      out_err;

  modport master (
    output in_valid, in_op, in_shamt, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_op, in_shamt, in_data, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/multi_channel_serial_shifter_shift_step.sv
// One-position combinational shift of a single lane; bit_out is the bit leaving the lane.
// Rotate wrap paths exist only when ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lane,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] next_lane,
  output logic             bit_out
);

  always_comb begin
    next_lane = lane;
    bit_out   = 1'b0;
    case (op)
      SLL: begin
        next_lane = {lane[WIDTH-2:0], 1'b0};
        bit_out   = lane[WIDTH-1];
      end
      SRL: begin
        next_lane = {1'b0, lane[WIDTH-1:1]};
        bit_out   = lane[0];
      end
      SRA: begin
        next_lane = {lane[WIDTH-1], lane[WIDTH-1:1]};
        bit_out   = lane[0];
      end
`ifdef ROTATE_EN
      ROL: begin
        next_lane = {lane[WIDTH-2:0], lane[WIDTH-1]};
        bit_out   = lane[WIDTH-1];
      end
      ROR: begin
        next_lane = {lane[0], lane[WIDTH-1:1]};
        bit_out   = lane[0];
      end
`endif
      default: begin
        next_lane = lane;
        bit_out   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_channel_serial_shifter.sv
// Iterative multi-lane shifter: one bit position per clock, valid/ready on both sides.
// ROTATE_EN enables ROL/ROR; without it those op codes report out_err.
module multi_channel_serial_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SHAMT_W  = $clog2(WIDTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  multi_channel_serial_shifter_if.slave bus
);

  localparam int DW = CHANNELS * WIDTH;

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic [SHAMT_W-1:0] count;
  logic [DW-1:0]      data_q;
  logic [CHANNELS-1:0] carry_q;
  logic               err_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [DW-1:0]      next_data;
  logic [CHANNELS-1:0] next_carry;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    shift_step #(.WIDTH(WIDTH)) u_step (
      .lane      (data_q[i*WIDTH +: WIDTH]),
      .op        (op_q),
      .next_lane (next_data[i*WIDTH +: WIDTH]),
      .bit_out   (next_carry[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      count       <= '0;
      data_q      <= '0;
      carry_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            op_q       <= bus.in_op;
            count      <= bus.in_shamt;
            carry_q    <= '0;
            err_q      <= !op_legal(bus.in_op);
            in_ready_q <= 1'b0;
            if (op_legal(bus.in_op) && bus.in_shamt != '0) begin
              state <= SHIFT;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q  <= next_data;
          carry_q <= next_carry;
          count   <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Results stay frozen until the consumer takes them.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_multi_channel_serial_shifter.sv
// Bench for multi_channel_serial_shifter: directed table, corner sequences, random vs reference model.
module tb_multi_channel_serial_shifter;
  import shifter_pkg::*;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int SW = $clog2(W);
  localparam int DW = W * CH;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  multi_channel_serial_shifter_if #(.WIDTH(W), .CHANNELS(CH), .SHAMT_W(SW)) bus ();

  multi_channel_serial_shifter #(.WIDTH(W), .CHANNELS(CH), .SHAMT_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    op;
    logic [SW-1:0] sh;
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    logic [CH-1:0] ec;
    logic          ee;
    int            lat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each lane shifted by sh in one go with plain operators.
  task automatic model(input logic [2:0] op, input int sh, input logic [DW-1:0] d,
                       output logic [DW-1:0] ed, output logic [CH-1:0] ec,
                       output logic ee, output int lat);
    logic legal;
    logic [W-1:0] x, r;
`ifdef ROTATE_EN
    legal = (op <= 3'd4);
`else
    legal = (op <= 3'd2);
`endif
    ed  = d;
    ec  = '0;
    ee  = !legal;
    lat = 1;
    if (legal && sh != 0) begin
      lat = sh + 1;
      for (int l = 0; l < CH; l++) begin
        x = d[l*W +: W];
        r = x;
        case (op)
          3'd0: begin r = x << sh;                      ec[l] = x[W-sh]; end
          3'd1: begin r = x >> sh;                      ec[l] = x[sh-1]; end
          3'd2: begin r = $signed(x) >>> sh;            ec[l] = x[sh-1]; end
          3'd3: begin r = (x << sh) | (x >> (W - sh));  ec[l] = x[W-sh]; end
          default: begin r = (x >> sh) | (x << (W - sh)); ec[l] = x[sh-1]; end
        endcase
        ed[l*W +: W] = r;
      end
    end
  endtask

  // Issue one request, wait for the result, hold it for 'stall' cycles, then consume.
  task automatic run_req(input logic [2:0] op, input logic [SW-1:0] sh, input logic [DW-1:0] d,
                         input int stall, output logic [DW-1:0] od, output logic [CH-1:0] oc,
                         output logic oe, output int lat);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_shamt = sh;
    bus.in_data  = d;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 3'd7;
    bus.in_shamt = ~sh;
    bus.in_data  = ~d;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    od = bus.out_data;
    oc = bus.out_carry;
    oe = bus.out_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      check("stall_data", 64'(bus.out_data), 64'(od));
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [DW-1:0] od, ed;
  logic [CH-1:0] oc, ec;
  logic          oe, ee;
  int            lat, elat, pulses;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_shamt  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{3'd0, 3'd1, 16'h4381, 16'h8602, 2'b01, 1'b0, 2};
    tbl[1] = '{3'd2, 3'd3, 16'h7F80, 16'h0FF0, 2'b10, 1'b0, 4};
`ifdef ROTATE_EN
    tbl[2] = '{3'd4, 3'd1, 16'h0201, 16'h0180, 2'b01, 1'b0, 2};
`else
    tbl[2] = '{3'd4, 3'd1, 16'h0201, 16'h0201, 2'b00, 1'b1, 1};
`endif
    tbl[3] = '{3'd1, 3'd0, 16'hABCD, 16'hABCD, 2'b00, 1'b0, 1};
    tbl[4] = '{3'd6, 3'd2, 16'h1234, 16'h1234, 2'b00, 1'b1, 1};
    tbl[5] = '{3'd1, 3'd7, 16'hC0FF, 16'h0101, 2'b11, 1'b0, 8};

    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_out_carry", 64'(bus.out_carry), 64'(0));
    check("rst_out_err",   64'(bus.out_err),   64'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].op, tbl[i].sh, tbl[i].d, 0, od, oc, oe, lat);
      check($sformatf("tbl%0d_data", i),  64'(od),  64'(tbl[i].ed));
      check($sformatf("tbl%0d_carry", i), 64'(oc),  64'(tbl[i].ec));
      check($sformatf("tbl%0d_err", i),   64'(oe),  64'(tbl[i].ee));
      check($sformatf("tbl%0d_lat", i),   64'(lat), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_ready", i), 64'(bus.in_ready), 64'(1));
    end

    // Back-pressure: five stalled cycles in DONE with a competing request.
    model(3'd0, 2, 16'h1234, ed, ec, ee, elat);
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_shamt = 3'd2; bus.in_data = 16'h1234;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clock); #1; lat++; end
    check("bp_lat", 64'(lat), 64'(elat));
    for (int s = 0; s < 5; s++) begin
      if (s == 1) begin bus.in_valid = 1'b1; bus.in_data = 16'hFFFF; bus.in_op = 3'd1; end
      check("bp_data",     64'(bus.out_data),  64'(ed));
      check("bp_carry",    64'(bus.out_carry), 64'(ec));
      check("bp_valid",    64'(bus.out_valid), 64'(1));
      check("bp_in_ready", 64'(bus.in_ready),  64'(0));
      @(posedge clock); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    check("bp_state_idle", 64'(dut.state),     64'(IDLE));
    check("bp_ready_back", 64'(bus.in_ready),  64'(1));
    check("bp_valid_drop", 64'(bus.out_valid), 64'(0));
    check("bp_no_capture", 64'(bus.out_data),  64'(ed));

    // Reset during SHIFT discards the request.
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_shamt = 3'd7; bus.in_data = 16'hFFFF;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mrst_state",     64'(dut.state),     64'(IDLE));
    check("mrst_in_ready",  64'(bus.in_ready),  64'(1));
    check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mrst_out_data",  64'(bus.out_data),  64'(0));
    check("mrst_out_carry", 64'(bus.out_carry), 64'(0));
    check("mrst_out_err",   64'(bus.out_err),   64'(0));
    pulses = 0;
    repeat (15) begin
      @(posedge clock); #1;
      if (bus.out_valid) pulses++;
    end
    check("mrst_no_pulse", 64'(pulses), 64'(0));

    // Random requests against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic [2:0]    rop;
      logic [SW-1:0] rsh;
      logic [DW-1:0] rd;
      int            rst_cyc;
      rop = 3'($urandom_range(0, 7));
      rsh = SW'($urandom_range(0, W - 1));
      rd  = DW'($urandom);
      rst_cyc = $urandom_range(0, 3);
      model(rop, int'(rsh), rd, ed, ec, ee, elat);
      run_req(rop, rsh, rd, rst_cyc, od, oc, oe, lat);
      check($sformatf("rnd%0d_data op%0d sh%0d d%h", k, rop, rsh, rd), 64'(od), 64'(ed));
      check($sformatf("rnd%0d_carry", k), 64'(oc),  64'(ec));
      check($sformatf("rnd%0d_err", k),   64'(oe),  64'(ee));
      check($sformatf("rnd%0d_lat", k),   64'(lat), 64'(elat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
